// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: opcode constants, controller state
// encoding and a small opcode-class helper. Also imported by the ALU.
package cpu_pkg;

  // Instruction opcodes (3-bit field of the instruction register)
  localparam logic [2:0] HLT  = 3'b000;
  localparam logic [2:0] SKZ  = 3'b001;
  localparam logic [2:0] ADD  = 3'b010;
  localparam logic [2:0] ANDD = 3'b011;
  localparam logic [2:0] XORR = 3'b100;
  localparam logic [2:0] LDA  = 3'b101;
  localparam logic [2:0] STO  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  // Controller states: IDLE, eight instruction phases, and a sticky halt
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S0     = 4'd1,
    ST_S1     = 4'd2,
    ST_S2     = 4'd3,
    ST_S3     = 4'd4,
    ST_S4     = 4'd5,
    ST_S5     = 4'd6,
    ST_S6     = 4'd7,
    ST_S7     = 4'd8,
    ST_HALTED = 4'd9
  } ctrl_state_t;

  // Opcodes that fetch an operand from memory into the ALU / accumulator
  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the simple accumulator CPU.
// Outputs are a pure decode of the state register, opcode and zero flag.
// Optional feature macro: CTRL_INSTR_CNT_EN adds a 16-bit retired-instruction
// counter on port instr_cnt (incremented on every S7 exit, wraps at 0xFFFF).
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [2:0]  opcode,
  input  logic        zero,
  output logic        rd,
  output logic        wr,
  output logic        load_ir,
  output logic        inc_pc,
  output logic        load_pc,
  output logic        load_acc,
  output logic        alu_ena,
  output logic        datactl_ena,
  output logic        halt
`ifdef CTRL_INSTR_CNT_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  ctrl_state_t state;
  ctrl_state_t state_next;

  // State register; reset overrides everything, including HALTED
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: fixed 8-phase walk; ena only matters in IDLE and at S7
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (ena) state_next = ST_S0;
      ST_S0:     state_next = ST_S1;
      ST_S1:     state_next = ST_S2;
      ST_S2:     state_next = ST_S3;
      ST_S3:     state_next = (opcode == HLT) ? ST_HALTED : ST_S4;
      ST_S4:     state_next = ST_S5;
      ST_S5:     state_next = ST_S6;
      ST_S6:     state_next = ST_S7;
      ST_S7:     state_next = ena ? ST_S0 : ST_IDLE;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode; every strobe defaults low so unlisted pairs stay quiet
  always_comb begin
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    alu_ena     = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    unique case (state)
      ST_S0, ST_S1: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        inc_pc  = 1'b1;
      end
      ST_S4: begin
        if (is_acc_op(opcode)) begin
          rd      = 1'b1;
          alu_ena = 1'b1;
        end
        if (opcode == SKZ) inc_pc  = zero;
        if (opcode == JMP) load_pc = 1'b1;
      end
      ST_S5: begin
        if (is_acc_op(opcode)) begin
          rd       = 1'b1;
          load_acc = 1'b1;
        end
        if (opcode == STO) datactl_ena = 1'b1;
      end
      ST_S6: begin
        if (opcode == SKZ) inc_pc = zero;
        if (opcode == STO) begin
          datactl_ena = 1'b1;
          wr          = 1'b1;
        end
      end
      ST_S7:     if (opcode == STO) datactl_ena = 1'b1;
      ST_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_INSTR_CNT_EN
  // Retired-instruction counter; S7 always exits next edge, so count on S7
  always_ff @(posedge clk) begin
    if (!rst_n)              instr_cnt <= 16'h0000;
    else if (state == ST_S7) instr_cnt <= instr_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: reset, each opcode class through all
// eight phases, ena drop at S3, HLT with ena toggling, mid-instruction reset.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [2:0]  opcode;
  logic        zero;
  logic        rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt;
`ifdef CTRL_INSTR_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] exp_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Output bit order: rd wr load_ir inc_pc load_pc load_acc alu_ena datactl_ena halt
  logic [8:0] outs;
  assign outs = {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt};

  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] FETCH = 9'b101100000;
  localparam logic [8:0] ALU4  = 9'b100000100;
  localparam logic [8:0] ACC5  = 9'b100001000;
  localparam logic [8:0] INCPC = 9'b000100000;
  localparam logic [8:0] LDPC  = 9'b000010000;
  localparam logic [8:0] DCTL  = 9'b000000010;
  localparam logic [8:0] WRD   = 9'b010000010;
  localparam logic [8:0] HALT  = 9'b000000001;

  logic [8:0] exp_tab [8];

  // Clock and DUT
  always #5 clk = ~clk;

  cpu_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .alu_ena     (alu_ena),
    .datactl_ena (datactl_ena),
    .halt        (halt)
`ifdef CTRL_INSTR_CNT_EN
    ,
    .instr_cnt   (instr_cnt)
`endif
  );

  // Advance one clock and settle just after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] exp);
    n_checks++;
    assert (outs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
    end
  endtask

`ifdef CTRL_INSTR_CNT_EN
  task automatic check_cnt(input string tag);
    n_checks++;
    assert (instr_cnt === exp_cnt)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, instr_cnt, exp_cnt);
    end
  endtask
`endif

  // Walk one instruction starting in S0, checking every phase against exp_tab;
  // drop_at >= 0 lowers ena right after that phase's check.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input int drop_at);
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_s%0d", name, i), exp_tab[i]);
      if (i == drop_at) ena = 1'b0;
      step();
    end
`ifdef CTRL_INSTR_CNT_EN
    exp_cnt = exp_cnt + 16'h0001;
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    opcode = 3'b010;
    zero   = 1'b0;
`ifdef CTRL_INSTR_CNT_EN
    exp_cnt = 16'h0000;
`endif

    // Reset held two clocks with ena high: IDLE, all quiet
    step();
    step();
    check("reset_idle", NONE);
`ifdef CTRL_INSTR_CNT_EN
    check_cnt("reset_cnt");
`endif
    rst_n = 1'b1;
    step();

    // ADD: operand read in S4/S5, next fetch exactly 8 clocks later
    exp_tab = '{FETCH, FETCH, NONE, NONE, ALU4, ACC5, NONE, NONE};
    run_instr("add", 3'b010, 1'b0, -1);

    // SKZ with zero=1 skips; with zero=0 only fetch increments
    exp_tab = '{FETCH, FETCH, NONE, NONE, INCPC, NONE, INCPC, NONE};
    run_instr("skz_z1", 3'b001, 1'b1, -1);
    exp_tab = '{FETCH, FETCH, NONE, NONE, NONE, NONE, NONE, NONE};
    run_instr("skz_z0", 3'b001, 1'b0, -1);

    // STO: bus driven S5..S7, write only in S6
    exp_tab = '{FETCH, FETCH, NONE, NONE, NONE, DCTL, WRD, DCTL};
    run_instr("sto", 3'b110, 1'b1, -1);

    // JMP: PC load in S4
    exp_tab = '{FETCH, FETCH, NONE, NONE, LDPC, NONE, NONE, NONE};
    run_instr("jmp", 3'b111, 1'b0, -1);

    // LDA with ena dropped in S3: completes, then parks in IDLE
    exp_tab = '{FETCH, FETCH, NONE, NONE, ALU4, ACC5, NONE, NONE};
    run_instr("lda_drop", 3'b101, 1'b0, 3);
    check("idle_after_drop", NONE);
    step();
    check("idle_hold", NONE);
`ifdef CTRL_INSTR_CNT_EN
    check_cnt("cnt_after_six");
`endif
    ena = 1'b1;
    step();
    check("resume_s0", FETCH);

    // Reset in the middle of an instruction (S2) returns to IDLE
    opcode = 3'b011;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mid_reset_idle", NONE);
`ifdef CTRL_INSTR_CNT_EN
    exp_cnt = 16'h0000;
    check_cnt("mid_reset_cnt");
`endif
    rst_n = 1'b1;
    step();

    // HLT: halt from the clock after S3, sticky for 20 clocks with ena toggling
    opcode = 3'b000;
    check("hlt_s0", FETCH);
    step();
    check("hlt_s1", FETCH);
    step();
    check("hlt_s2", NONE);
    step();
    check("hlt_s3", NONE);
    step();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted_%0d", i), HALT);
      ena = ~ena;
      step();
    end
`ifdef CTRL_INSTR_CNT_EN
    check_cnt("hlt_not_counted");
`endif

    // Single reset cycle leaves HALTED, then normal fetch resumes
    rst_n = 1'b0;
    ena   = 1'b1;
    step();
    check("unhalt_idle", NONE);
    rst_n = 1'b1;
    step();
    check("unhalt_s0", FETCH);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
